mux4_rr_arbiter: RTL and testbench
==================================

Name: mux4_rr_arbiter

Overview:
- Shares one 4:1 WIDTH-bit select datapath (output channel) among four requesters.
- Uses round-robin arbitration with packet locking: a multi-beat transfer is never interleaved with another requester.
- Drives the select internally and presents one registered output beat with a valid/ready handshake.
- Sits between four producer ports and a single downstream consumer.

Parameters:
- WIDTH, 4, data bits per beat on every port.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous reset, active low.
- in_valid  input  4  bit i means requester i presents a beat.
- in_last  input  4  bit i marks requester i's current beat as the final beat of its packet.
- d0, d1, d2, d3  input  WIDTH each  requester data.
- in_ready  output  4  bit i means requester i's beat is accepted this cycle.
- out_valid  output  1  the output register holds a beat.
- out_data  output  WIDTH  registered beat data.
- out_last  output  1  registered last flag.
- out_sel  output  2  index of the requester that produced the registered beat.
- out_ready  input  1  consumer accepts the beat this cycle.

Behaviour:
- Interface: one clock, clk. Reset rst_n is asynchronous and active-low.
- Reset values (asserted immediately, no clock needed): out_valid=0, out_data=0, out_last=0, out_sel=0, priority pointer ptr=0, state=IDLE, lock owner=0.
- in_ready is 0 while rst_n is low.
- Load enable: load_ok = !out_valid || out_ready.
  - The output register is a one-deep pipeline stage.
  - With continuous out_ready=1, throughput is one beat per cycle.
  - Latency from acceptance to out_valid is 1 cycle.
- States:
  - IDLE: no packet in progress.
    - Candidate = first i with in_valid[i]=1, scanning ptr, ptr+1, ptr+2, ptr+3 (mod 4).
  - LOCKED: packet in progress.
    - Candidate = lock owner only, and only if its in_valid is 1.
    - Other requesters get in_ready=0 even when the owner is idle.
- Combinational grant: in_ready[i] = (i == candidate) && in_valid[i] && load_ok. At most one bit of in_ready is set.
- On acceptance from requester i:
  - out_data <= d_i, out_last <= in_last[i], out_sel <= i, out_valid <= 1.
  - If in_last[i]=0: state <= LOCKED, owner <= i.
  - If in_last[i]=1: state <= IDLE, ptr <= (i+1) mod 4. The pointer wraps 3 -> 0.
- Single-beat packets (last=1) go directly IDLE -> IDLE and advance ptr.
- No acceptance and out_ready=1: out_valid <= 0. The data, last and sel registers hold their old values.
- No acceptance and out_ready=0: all output registers hold.
- Simultaneous out_ready=1 and acceptance in the same cycle: the new beat replaces the old one with no bubble.
- ptr changes only on a last-beat acceptance. Non-accepted cycles and non-last beats leave it unchanged.
- Requester data and last are sampled only on acceptance. Changes while in_ready=0 are ignored.
- rst_n low mid-packet: clears the lock and discards the registered beat. After release, arbitration restarts from requester 0.
- No combinational path from in_valid to out_valid. in_ready depends combinationally on in_valid, out_valid and out_ready.

Test Plan:
- Reset, then in_valid=4'b1111, in_last=4'b1111, d0..d3=1,2,3,4, out_ready=1 held -> out_sel sequence 0,1,2,3,0 on consecutive cycles, out_data 1,2,3,4,1, out_valid continuously 1 from the second cycle.
- Requester 1 sends 3 beats A,B,C (last on C) while requesters 0 and 2 stay valid; ptr=1 at packet start -> out_data A,B,C all with out_sel=1, in_ready[0]=in_ready[2]=0 throughout; next grant goes to 2, then 0.
- Lock with owner gap: requester 2 sends beat 1 (last=0), drops in_valid for 2 cycles while requester 3 is valid, then sends beat 2 (last=1) -> in_ready[3] stays 0 during the gap; requester 3 is granted only after the last beat.
- Backpressure: out_ready=0 for 3 cycles with requester 0 valid -> out_valid=1 and out_data stable; in_ready[0]=0 after the first acceptance; on out_ready=1, the next beat is accepted that same cycle.
- Wrap: ptr=3 (after requester 2's last beat), in_valid=4'b1001 -> requester 3 granted first, then requester 0.
- Assert rst_n low asynchronously mid-packet from requester 3 -> out_valid drops immediately without a clock edge; after release with in_valid=4'b1010, requester 1 is granted first.

Source files
------------

// File: rtl/mux4_rr_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module : mux4_rr_arbiter_if
// Brief  : Producer/consumer handshake bundle for the 4-way round-robin mux.
// Rev    : 1.0  initial release
// ============================================================================
interface mux4_rr_arbiter_if #(
    parameter int WIDTH = 4
);
    logic [3:0]       in_valid;
    logic [3:0]       in_last;
    logic [WIDTH-1:0] d0;
    logic [WIDTH-1:0] d1;
    logic [WIDTH-1:0] d2;
    logic [WIDTH-1:0] d3;
    logic [3:0]       in_ready;
    logic             out_valid;
    logic [WIDTH-1:0] out_data;
    logic             out_last;
    logic [1:0]       out_sel;
    logic             out_ready;

    modport slave (
        input  in_valid, in_last, d0, d1, d2, d3, out_ready,
        output in_ready, out_valid, out_data, out_last, out_sel
    );

    modport master (
        output in_valid, in_last, d0, d1, d2, d3, out_ready,
        input  in_ready, out_valid, out_data, out_last, out_sel
    );
endinterface
`default_nettype wire

// File: rtl/mux4_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module : mux4_rr_arbiter
// Brief  : 4:1 round-robin packet-locking mux with a registered output beat.
// Rev    : 1.0  initial release
// ============================================================================
module mux4_rr_arbiter #(
    parameter int WIDTH = 4
) (
    input wire                 clk,
    input wire                 rst_n,
    mux4_rr_arbiter_if.slave   bus
);
    localparam int c_NUM_REQ = 4;

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } state_t;

    state_t           r_state;
    logic [1:0]       r_ptr;
    logic [1:0]       r_owner;
    logic             r_out_valid;
    logic [WIDTH-1:0] r_out_data;
    logic             r_out_last;
    logic [1:0]       r_out_sel;

    logic             w_load_ok;
    logic             w_found;
    logic [1:0]       w_cand;
    logic [1:0]       w_idx;
    logic             w_accept;
    logic [WIDTH-1:0] w_data;
    logic             w_last;

    assign w_load_ok = !r_out_valid || bus.out_ready;

    // Scan from the highest offset down so the lowest offset from r_ptr wins.
    always_comb begin
        w_found = 1'b0;
        w_cand  = r_ptr;
        w_idx   = r_ptr;
        if (r_state == LOCKED) begin
            w_cand  = r_owner;
            w_found = bus.in_valid[r_owner];
        end else begin
            for (int k = c_NUM_REQ - 1; k >= 0; k--) begin
                w_idx = r_ptr + 2'(k);
                if (bus.in_valid[w_idx]) begin
                    w_cand  = w_idx;
                    w_found = 1'b1;
                end
            end
        end
    end

    assign w_accept     = w_found && w_load_ok && rst_n;
    assign bus.in_ready = w_accept ? (4'b0001 << w_cand) : 4'b0000;

    always_comb begin
        w_data = bus.d0;
        case (w_cand)
            2'd0:    w_data = bus.d0;
            2'd1:    w_data = bus.d1;
            2'd2:    w_data = bus.d2;
            default: w_data = bus.d3;
        endcase
    end

    assign w_last = bus.in_last[w_cand];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_ptr       <= 2'd0;
            r_owner     <= 2'd0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_last  <= 1'b0;
            r_out_sel   <= 2'd0;
        end else if (w_accept) begin
            r_out_valid <= 1'b1;
            r_out_data  <= w_data;
            r_out_last  <= w_last;
            r_out_sel   <= w_cand;
            if (w_last) begin
                r_state <= IDLE;
                r_ptr   <= w_cand + 2'd1;
            end else begin
                r_state <= LOCKED;
                r_owner <= w_cand;
            end
        end else if (bus.out_ready) begin
            // Drained with nothing new: payload registers keep their old values.
            r_out_valid <= 1'b0;
        end
    end

    assign bus.out_valid = r_out_valid;
    assign bus.out_data  = r_out_data;
    assign bus.out_last  = r_out_last;
    assign bus.out_sel   = r_out_sel;

endmodule
`default_nettype wire

// File: tb/tb_mux4_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module : tb_mux4_rr_arbiter
// Brief  : Scoreboard bench for mux4_rr_arbiter with per-requester beat sources.
// Rev    : 1.0  initial release
// ============================================================================
module tb_mux4_rr_arbiter;
    localparam int WIDTH = 4;
    localparam int c_DEPTH = 32;

    typedef struct packed {
        logic [WIDTH-1:0] data;
        logic             last;
        logic [1:0]       sel;
    } beat_t;

    logic clk;
    logic rst_n;

    mux4_rr_arbiter_if #(.WIDTH(WIDTH)) bus ();

    mux4_rr_arbiter #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Per-requester beat sources: data, last flag and idle cycles before the beat.
    int src_data [4][c_DEPTH];
    bit src_last [4][c_DEPTH];
    int src_gap  [4][c_DEPTH];
    int head [4];
    int tail [4];

    bit [3:0]         lane_valid;
    bit [3:0]         lane_last;
    logic [WIDTH-1:0] lane_d [4];
    bit [3:0]         acc;
    bit               rnd_ready;
    int               stall;

    // Reference arbitration state.
    int    m_ptr;
    bit    m_locked;
    int    m_owner;
    bit    m_out_valid;
    beat_t exp_q [$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic push_beat(input int r, input int data, input bit last, input int gap);
        src_data[r][tail[r]] = data;
        src_last[r][tail[r]] = last;
        src_gap[r][tail[r]]  = gap;
        tail[r]++;
    endtask

    task automatic clear_all();
        for (int i = 0; i < 4; i++) begin
            head[i] = 0;
            tail[i] = 0;
        end
        acc         = '0;
        m_ptr       = 0;
        m_locked    = 1'b0;
        m_owner     = 0;
        m_out_valid = 1'b0;
        exp_q.delete();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        clear_all();
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_out_data",  bus.out_data, 0);
        check("rst_out_last",  bus.out_last, 0);
        check("rst_out_sel",   bus.out_sel, 0);
        #1;
        rst_n = 1'b1;
    endtask

    function automatic bit busy();
        bit b;
        b = (exp_q.size() != 0) || m_out_valid;
        for (int i = 0; i < 4; i++)
            if (head[i] != tail[i]) b = 1'b1;
        return b;
    endfunction

    task automatic wait_done(input int max_cycles);
        int n;
        n = 0;
        while (busy() && n < max_cycles) begin
            @(posedge clk);
            n++;
        end
        check("drain_busy", 32'(busy()), 0);
    endtask

    // Driver: retire accepted beats, then present each source's head beat.
    always @(posedge clk) begin
        #1;
        for (int i = 0; i < 4; i++) begin
            if (acc[i] && head[i] != tail[i]) head[i]++;
        end
        acc = '0;
        for (int i = 0; i < 4; i++) begin
            lane_valid[i] = 1'b0;
            lane_last[i]  = 1'($urandom);
            lane_d[i]     = WIDTH'($urandom);
            if (head[i] != tail[i]) begin
                if (src_gap[i][head[i]] > 0) begin
                    src_gap[i][head[i]]--;
                end else begin
                    lane_valid[i] = 1'b1;
                    lane_last[i]  = src_last[i][head[i]];
                    lane_d[i]     = WIDTH'(src_data[i][head[i]]);
                end
            end
        end
        bus.in_valid = lane_valid;
        bus.in_last  = lane_last;
        bus.d0 = lane_d[0];
        bus.d1 = lane_d[1];
        bus.d2 = lane_d[2];
        bus.d3 = lane_d[3];
        if (rnd_ready) begin
            bus.out_ready = 1'($urandom);
        end else if (stall > 0) begin
            bus.out_ready = 1'b0;
            stall--;
        end else begin
            bus.out_ready = 1'b1;
        end
    end

    // Monitor: compare output beat against the scoreboard, then predict the grant.
    always @(negedge clk) begin : mon
        int    gnt;
        int    idx;
        beat_t b;
        if (rst_n) begin
            if (m_out_valid) begin
                check("out_valid", bus.out_valid, 1);
                if (exp_q.size() == 0) begin
                    check("exp_q_size", 0, 1);
                end else begin
                    b = exp_q[0];
                    check("out_data", bus.out_data, b.data);
                    check("out_last", bus.out_last, b.last);
                    check("out_sel",  bus.out_sel,  b.sel);
                    if (bus.out_ready) void'(exp_q.pop_front());
                end
            end else begin
                check("out_valid", bus.out_valid, 0);
            end

            gnt = -1;
            if (m_locked) begin
                if (lane_valid[m_owner]) gnt = m_owner;
            end else begin
                for (int k = 0; k < 4; k++) begin
                    idx = (m_ptr + k) % 4;
                    if (gnt < 0 && lane_valid[idx]) gnt = idx;
                end
            end
            if (m_out_valid && !bus.out_ready) gnt = -1;

            check("in_ready", bus.in_ready, (gnt >= 0) ? (32'd1 << gnt) : 32'd0);

            if (gnt >= 0) begin
                acc[gnt] = 1'b1;
                b.data = lane_d[gnt];
                b.last = lane_last[gnt];
                b.sel  = 2'(gnt);
                exp_q.push_back(b);
                m_out_valid = 1'b1;
                if (lane_last[gnt]) begin
                    m_locked = 1'b0;
                    m_ptr    = (gnt + 1) % 4;
                end else begin
                    m_locked = 1'b1;
                    m_owner  = gnt;
                end
            end else if (bus.out_ready) begin
                m_out_valid = 1'b0;
            end
        end
    end

    initial begin
        rst_n         = 1'b0;
        rnd_ready     = 1'b0;
        stall         = 0;
        bus.in_valid  = '0;
        bus.in_last   = '0;
        bus.d0        = '0;
        bus.d1        = '0;
        bus.d2        = '0;
        bus.d3        = '0;
        bus.out_ready = 1'b1;

        // All four requesters, single-beat packets, continuous ready.
        do_reset();
        for (int r = 0; r < 4; r++) begin
            push_beat(r, r + 1, 1'b1, 0);
            push_beat(r, r + 1, 1'b1, 0);
        end
        wait_done(100);

        // Requester 1 packet of three beats locks out 0 and 2.
        do_reset();
        push_beat(0, 4'h9, 1'b1, 0);
        push_beat(0, 4'h8, 1'b1, 0);
        push_beat(1, 4'hA, 1'b0, 0);
        push_beat(1, 4'hB, 1'b0, 0);
        push_beat(1, 4'hC, 1'b1, 0);
        push_beat(2, 4'h5, 1'b1, 0);
        wait_done(100);

        // Owner gap on requester 2, then wrap from ptr=3 with valid=1001.
        do_reset();
        push_beat(2, 4'h6, 1'b0, 0);
        push_beat(2, 4'h7, 1'b1, 2);
        push_beat(3, 4'hE, 1'b1, 0);
        push_beat(0, 4'h1, 1'b1, 2);
        wait_done(100);

        // Backpressure: ready low for three cycles after the first acceptance.
        do_reset();
        push_beat(0, 4'h3, 1'b1, 0);
        push_beat(0, 4'h4, 1'b1, 0);
        push_beat(0, 4'h5, 1'b1, 0);
        stall = 4;
        wait_done(100);

        // Asynchronous reset in the middle of a requester 3 packet.
        do_reset();
        push_beat(3, 4'hD, 1'b0, 0);
        push_beat(3, 4'hE, 1'b0, 0);
        push_beat(3, 4'hF, 1'b1, 0);
        @(posedge clk);
        @(posedge clk);
        #3;
        check("pre_rst_out_valid", bus.out_valid, 1);
        rst_n = 1'b0;
        #1;
        check("async_out_valid", bus.out_valid, 0);
        check("async_in_ready",  bus.in_ready, 0);
        do_reset();
        push_beat(1, 4'h2, 1'b1, 0);
        push_beat(3, 4'h7, 1'b1, 0);
        wait_done(100);

        // Random packets with random backpressure.
        for (int rep = 0; rep < 2; rep++) begin
            do_reset();
            rnd_ready = 1'b1;
            for (int r = 0; r < 4; r++) begin
                for (int p = 0; p < 3; p++) begin
                    int len;
                    len = $urandom_range(1, 3);
                    for (int j = 0; j < len; j++)
                        push_beat(r, $urandom_range(0, 15), (j == len - 1),
                                  (j == 0) ? $urandom_range(0, 2) : $urandom_range(0, 1));
                end
            end
            wait_done(1000);
            rnd_ready = 1'b0;
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
